// File: rtl/axo_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS layout and serializer state encoding.
package axo_uart_pkg;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam logic [3:0] OFF_DIV    = 4'h8;

  localparam int unsigned STAT_FULL_BIT  = 0;
  localparam int unsigned STAT_EMPTY_BIT = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  localparam logic [1:0] ASIZE_BYTE = 2'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [31:0] pack_status(input logic       full,
                                              input logic       empty,
                                              input logic       busy,
                                              input logic [7:0] count);
    logic [31:0] s;
    s                       = '0;
    s[STAT_FULL_BIT]        = full;
    s[STAT_EMPTY_BIT]       = empty;
    s[STAT_BUSY_BIT]        = busy;
    s[STAT_COUNT_LSB +: 8]  = count;
    return s;
  endfunction

endpackage

// File: rtl/axo_uart_tx_mmio_fifo.sv
// Synchronous FIFO with occupancy count; pushes when full and pops when
// empty are dropped. DEPTH must be a power of two so pointers wrap naturally.
module axo_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop  && !o_empty;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/axo_uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: bus decode, DIV register, TX FIFO and
// the serializer FSM. Stalls TXDATA stores while the FIFO is full.
module axo_uart_tx_mmio
  import axo_uart_pkg::*;
#(
  parameter logic [31:0] BASE        = 32'h0000_0100,
  parameter int unsigned DEPTH       = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_re,
  input  logic             mem_we,
  input  logic [1:0]       mem_asize,
  output logic             mem_ready,
  input  logic [31:0]      mem_addr,
  inout  wire logic [31:0] mem_data,
  output logic             txd,
  output logic             irq_tx
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          w_sel;
  logic [3:0]    w_off;
  logic          w_push_req;
  logic          w_push;
  logic          w_div_we;
  logic [31:0]   w_rdata;
  logic          w_unused;

  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [7:0]    w_fifo_data;
  logic          w_pop;
  logic          w_bit_end;

  logic [15:0]   r_div;
  tx_state_t     r_state;
  logic [2:0]    r_bitcnt;
  logic [15:0]   r_baud;
  logic [15:0]   r_div_q;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_irq;

  assign w_sel      = (mem_addr[31:4] == BASE[31:4]);
  assign w_off      = mem_addr[3:0];
  assign w_push_req = w_sel && mem_we && (w_off == OFF_TXDATA);
  assign w_div_we   = w_sel && mem_we && (w_off == OFF_DIV);

  // full is registered state, so a pop this cycle cannot release a stalled push
  assign mem_ready  = !(w_push_req && w_full);
  assign w_push     = w_push_req && !w_full;

  assign w_unused   = ^{mem_data[31:16]};

  axo_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_push  (w_push),
    .i_data  (mem_data[7:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_rdata = '0;
    case (w_off)
      OFF_STATUS: w_rdata = pack_status(w_full, w_empty, (r_state != IDLE),
                                        8'(w_count));
      OFF_DIV:    w_rdata = {16'h0000, r_div};
      default:    w_rdata = '0;
    endcase
  end

  assign mem_data = (w_sel && mem_re) ? w_rdata : 'z;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= DEFAULT_DIV;
    end else if (w_div_we) begin
      if (mem_asize == ASIZE_BYTE) begin
        r_div[7:0] <= mem_data[7:0];
      end else begin
        r_div <= mem_data[15:0];
      end
    end
  end

  assign w_bit_end = (r_baud == r_div_q);
  assign w_pop     = !w_empty &&
                     ((r_state == IDLE) || ((r_state == STOP) && w_bit_end));

  // A pop always starts a frame, whether leaving IDLE or chaining out of STOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_bitcnt <= '0;
      r_baud   <= '0;
      r_div_q  <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_irq    <= 1'b1;
    end else begin
      r_irq <= w_empty && (r_state == IDLE);
      if (w_pop) begin
        r_shift  <= w_fifo_data;
        r_div_q  <= r_div;
        r_baud   <= '0;
        r_bitcnt <= '0;
        r_txd    <= 1'b0;
        r_state  <= START;
      end else begin
        case (r_state)
          IDLE: begin
            r_txd <= 1'b1;
          end
          START: begin
            if (w_bit_end) begin
              r_baud  <= '0;
              r_txd   <= r_shift[0];
              r_state <= DATA;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          DATA: begin
            if (w_bit_end) begin
              r_baud <= '0;
              if (r_bitcnt == 3'd7) begin
                r_txd   <= 1'b1;
                r_state <= STOP;
              end else begin
                r_bitcnt <= r_bitcnt + 3'd1;
                r_shift  <= {1'b0, r_shift[7:1]};
                r_txd    <= r_shift[1];
              end
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          STOP: begin
            if (w_bit_end) begin
              r_baud  <= '0;
              r_state <= IDLE;
            end else begin
              r_baud <= r_baud + 16'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign txd    = r_txd;
  assign irq_tx = r_irq;

endmodule

// File: tb/tb_axo_uart_tx_mmio.sv
// Bench for axo_uart_tx_mmio: bus stores feed a byte scoreboard, a txd
// monitor decodes frames and checks every bit period against the DIV model.
module tb_axo_uart_tx_mmio;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        mem_re    = 1'b0;
  logic        mem_we    = 1'b0;
  logic [1:0]  mem_asize = 2'd2;
  logic [31:0] mem_addr  = '0;
  wire  [31:0] mem_data;
  logic        mem_ready;
  logic        txd;
  logic        irq_tx;

  logic        tb_drv   = 1'b0;
  logic [31:0] tb_wdata = '0;

  assign mem_data = tb_drv ? tb_wdata : 'z;

  axo_uart_tx_mmio #(
    .BASE        (BASE),
    .DEPTH       (8),
    .DEFAULT_DIV (16'd15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_asize (mem_asize),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .txd       (txd),
    .irq_tx    (irq_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  logic [7:0]  sb_q[$];
  logic [15:0] sh_div = 16'd15;
  int          cyc = 0;
  int          starts[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Frame monitor: every sample of every bit period must match the model
  logic       mon_active = 1'b0;
  logic [7:0] mon_exp    = '0;
  logic [7:0] mon_obs    = '0;
  logic       exp_lvl;
  int         mon_d, mon_cnt, mon_glitch, bi, pos;
  int         frames_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && txd == 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        mon_glitch = 0;
        mon_obs    = '0;
        mon_d      = int'(sh_div) + 1;
        starts.push_back(cyc);
        if (sb_q.size() == 0) begin
          check_eq("spurious_frame", 32'd1, 32'd0);
          mon_exp = '0;
        end else begin
          mon_exp = sb_q.pop_front();
        end
      end
      if (mon_active) begin
        bi  = mon_cnt / mon_d;
        pos = mon_cnt % mon_d;
        if (bi == 0)      exp_lvl = 1'b0;
        else if (bi == 9) exp_lvl = 1'b1;
        else              exp_lvl = mon_exp[bi-1];
        if (txd !== exp_lvl) mon_glitch++;
        if (bi >= 1 && bi <= 8 && pos == mon_d / 2) mon_obs[bi-1] = txd;
        mon_cnt++;
        if (mon_cnt == 10 * mon_d) begin
          check_eq("frame_byte", 32'(mon_obs), 32'(mon_exp));
          check_eq("frame_timing", 32'(mon_glitch), 32'd0);
          mon_active = 1'b0;
          frames_done++;
        end
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] asize, output int stalls);
    logic ok;
    @(negedge clk);
    mem_addr  = addr;
    mem_asize = asize;
    mem_we    = 1'b1;
    tb_wdata  = data;
    tb_drv    = 1'b1;
    stalls    = 0;
    #1;
    while (!mem_ready && stalls < 500) begin
      @(negedge clk);
      #1;
      stalls++;
    end
    ok = mem_ready;
    if (!ok) check_eq("write_timeout", 32'd0, 32'd1);
    else if (addr == BASE + 32'h0) sb_q.push_back(data[7:0]);
    @(posedge clk);
    #1;
    mem_we = 1'b0;
    tb_drv = 1'b0;
    if (ok && addr == BASE + 32'h8) begin
      if (asize == 2'd0) sh_div[7:0] = data[7:0];
      else               sh_div      = data[15:0];
    end
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] data, input logic [1:0] asize);
    int s;
    bus_write(BASE + 32'(off), data, asize, s);
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data, output logic rdy);
    @(negedge clk);
    mem_addr = addr;
    mem_re   = 1'b1;
    #1;
    data = mem_data;
    rdy  = mem_ready;
    @(posedge clk);
    #1;
    mem_re = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_read(BASE + 32'(off), d, r);
    check_eq(tag, d, exp);
  endtask

  task automatic drain(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      #2;
      if (sb_q.size() == 0 && !mon_active) break;
    end
    check_eq("drain_timeout", 32'(k < limit), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          st, st_sum, fr, bad;
    logic [31:0] d;
    logic        r;

    // Reset state, observed while rst_n is held low
    repeat (3) @(negedge clk);
    check_eq("rst_txd", 32'(txd), 32'd1);
    check_eq("rst_irq", 32'(irq_tx), 32'd1);
    check_eq("rst_ready", 32'(mem_ready), 32'd1);
    rd_check("rst_status", 4'h4, 32'h0000_0002);
    rd_check("rst_div", 4'h8, 32'h0000_000F);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame at DIV=3, start-bit latency and irq behaviour
    wr(4'h8, 32'd3, 2'd2);
    wr(4'h0, 32'h0000_0055, 2'd0);
    check_eq("txd_before_start", 32'(txd), 32'd1);
    @(posedge clk);
    #1;
    check_eq("txd_start_latency", 32'(txd), 32'd0);
    check_eq("irq_while_busy", 32'(irq_tx), 32'd0);
    rd_check("status_busy", 4'h4, 32'h0000_0006);
    drain(200);
    repeat (2) @(negedge clk);
    check_eq("irq_after_frame", 32'(irq_tx), 32'd1);
    check_eq("txd_idle", 32'(txd), 32'd1);
    rd_check("status_idle", 4'h4, 32'h0000_0002);

    // Burst beyond FIFO depth while one frame is already in flight
    starts.delete();
    wr(4'h0, 32'h40, 2'd0);
    st_sum = 0;
    for (int i = 0; i < 8; i++) begin
      bus_write(BASE, 32'h41 + 32'(i), 2'd2, st);
      st_sum += st;
    end
    check_eq("burst_no_stall", 32'(st_sum), 32'd0);
    rd_check("status_full", 4'h4, 32'h0000_0805);
    bus_write(BASE, 32'h49, 2'd0, st);
    check_eq("ninth_stall_cycles", 32'(st), 32'd32);
    drain(1000);
    check_eq("burst_frames", 32'(starts.size()), 32'd10);
    bad = 0;
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != 40) bad++;
    check_eq("burst_back_to_back", 32'(bad), 32'd0);

    // DIV change mid-frame applies only to the next frame
    starts.delete();
    wr(4'h0, 32'h3C, 2'd0);
    wr(4'h0, 32'hA5, 2'd0);
    repeat (10) @(negedge clk);
    wr(4'h8, 32'd7, 2'd1);
    drain(500);
    check_eq("div_change_frames", 32'(starts.size()), 32'd2);
    check_eq("div_change_len1", 32'(starts[1] - starts[0]), 32'd40);

    // Reset in the middle of a data bit with bytes queued
    wr(4'h8, 32'd3, 2'd2);
    wr(4'h0, 32'h11, 2'd0);
    wr(4'h0, 32'h22, 2'd0);
    wr(4'h0, 32'h33, 2'd0);
    repeat (15) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_txd", 32'(txd), 32'd1);
    check_eq("rst_mid_irq", 32'(irq_tx), 32'd1);
    sb_q.delete();
    sh_div = 16'd15;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_check("post_rst_status", 4'h4, 32'h0000_0002);
    rd_check("post_rst_div", 4'h8, 32'h0000_000F);
    fr = frames_done;
    repeat (200) @(negedge clk);
    check_eq("no_residual_frame", 32'(frames_done), 32'(fr));
    check_eq("post_rst_txd", 32'(txd), 32'd1);

    // Register map corners
    rd_check("offset_c_reads_0", 4'hC, 32'h0);
    rd_check("txdata_reads_0", 4'h0, 32'h0);
    wr(4'h8, 32'h0000_1234, 2'd2);
    wr(4'h8, 32'hFFFF_FFAB, 2'd0);
    rd_check("div_byte_write", 4'h8, 32'h0000_12AB);
    wr(4'h8, 32'hFFFF_5678, 2'd1);
    rd_check("div_half_write", 4'h8, 32'h0000_5678);
    wr(4'h4, 32'hFFFF_FFFF, 2'd2);
    rd_check("status_write_ignored", 4'h4, 32'h0000_0002);
    bus_read(BASE + 32'h10, d, r);
    check_eq("unsel_ready", 32'(r), 32'd1);
    check_eq("unsel_undriven", 32'(d === 32'hzzzz_zzzz || d === 32'h0), 32'd1);
    bus_read(BASE + 32'h18, d, r);
    check_eq("unsel_div_alias", 32'(d === 32'hzzzz_zzzz || d === 32'h0), 32'd1);
    bus_write(BASE + 32'h10, 32'h77, 2'd0, st);
    check_eq("unsel_write_ready", 32'(st), 32'd0);
    repeat (5) @(negedge clk);
    rd_check("unsel_no_push", 4'h4, 32'h0000_0002);

    // DIV=0: one clock per bit, back-to-back
    starts.delete();
    wr(4'h8, 32'd0, 2'd2);
    wr(4'h0, 32'h96, 2'd0);
    wr(4'h0, 32'h69, 2'd1);
    drain(200);
    check_eq("div0_frames", 32'(starts.size()), 32'd2);
    check_eq("div0_spacing", 32'(starts[1] - starts[0]), 32'd10);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
